// File: rtl/axi_slave_mem.sv
// AXI slave backed by a small word-addressed memory. Write and read bursts are
// handled by independent FSMs that share the array; all outputs are registered.
module axi_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int MI_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [7:0]        wcnt_q, wcnt_d, wlen_q, wlen_d;
  logic              werr_q, werr_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic [7:0]        rcnt_q, rcnt_d, rlen_q, rlen_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic w_in_range_s, w_last_cnt_s, w_beat_err_s, w_done_s, mem_we_s;
  logic ld_s, ld_in_range_s;
  logic [IDX_W-1:0] ld_idx_s;
  logic [7:0] ld_cnt_s, ld_len_s;
  logic unused_s;

  assign unused_s = ^{awaddr[1:0], araddr[1:0]};

  assign aw_hs_s = awvalid & awready_q;
  assign w_hs_s  = wvalid & wready_q;
  assign b_hs_s  = bvalid_q & bready;
  assign ar_hs_s = arvalid & arready_q;
  assign r_hs_s  = rvalid_q & rready;

  // A beat is in error when out of range or when wlast disagrees with the beat count.
  assign w_in_range_s = (widx_q < DEPTH_L);
  assign w_last_cnt_s = (wcnt_q == wlen_q);
  assign w_beat_err_s = ~w_in_range_s | (w_last_cnt_s ^ wlast);
  assign w_done_s     = w_last_cnt_s | wlast;
  assign mem_we_s     = w_hs_s & w_in_range_s;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) w_state_q <= W_IDLE;
    else         w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs_s) w_state_d = W_DATA; else w_state_d = W_IDLE;
      W_DATA:  if (w_hs_s && w_done_s) w_state_d = W_RESP; else w_state_d = W_DATA;
      W_RESP:  if (b_hs_s) w_state_d = W_IDLE; else w_state_d = W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    widx_d    = widx_q;
    wcnt_d    = wcnt_q;
    wlen_d    = wlen_q;
    werr_d    = werr_q;
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    if (aw_hs_s) begin
      widx_d = awaddr[ADDR_W-1:2];
      wcnt_d = 8'd0;
      wlen_d = awlen;
      werr_d = 1'b0;
    end else if (w_hs_s) begin
      widx_d = widx_q + IDX_W'(1);
      wcnt_d = wcnt_q + 8'd1;
      werr_d = werr_q | w_beat_err_s;
    end else begin
      werr_d = werr_q;
    end
    if (w_state_d == W_RESP) bresp_d = werr_d ? RESP_SLVERR : RESP_OKAY;
    else                     bresp_d = RESP_OKAY;
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      widx_q    <= '0;
      wcnt_q    <= 8'd0;
      wlen_q    <= 8'd0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      widx_q    <= widx_d;
      wcnt_q    <= wcnt_d;
      wlen_q    <= wlen_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we_s) begin
      mem_q[widx_q[MI_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) r_state_q <= R_IDLE;
    else         r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs_s) r_state_d = R_DATA; else r_state_d = R_IDLE;
      R_DATA:  if (r_hs_s && rlast_q) r_state_d = R_IDLE; else r_state_d = R_DATA;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Select which beat (if any) is loaded into the read output registers this edge.
  always_comb begin
    ld_s     = 1'b0;
    ld_idx_s = ridx_q;
    ld_cnt_s = rcnt_q;
    ld_len_s = rlen_q;
    if (ar_hs_s) begin
      ld_s     = 1'b1;
      ld_idx_s = araddr[ADDR_W-1:2];
      ld_cnt_s = 8'd0;
      ld_len_s = arlen;
    end else if (r_hs_s && !rlast_q) begin
      ld_s     = 1'b1;
      ld_idx_s = ridx_q + IDX_W'(1);
      ld_cnt_s = rcnt_q + 8'd1;
    end else begin
      ld_s     = 1'b0;
    end
  end

  assign ld_in_range_s = (ld_idx_s < DEPTH_L);

  always_comb begin
    ridx_d    = ridx_q;
    rcnt_d    = rcnt_q;
    rlen_d    = rlen_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    if (ld_s) begin
      ridx_d  = ld_idx_s;
      rcnt_d  = ld_cnt_s;
      rlen_d  = ld_len_s;
      rlast_d = (ld_cnt_s == ld_len_s);
      if (ld_in_range_s) begin
        rdata_d = mem_q[ld_idx_s[MI_W-1:0]];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end else if (r_hs_s) begin
      rdata_d = '0;
      rresp_d = RESP_OKAY;
      rlast_d = 1'b0;
    end else begin
      rlast_d = rlast_q;
    end
  end

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      ridx_q    <= '0;
      rcnt_q    <= 8'd0;
      rlen_q    <= 8'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      ridx_q    <= ridx_d;
      rcnt_q    <= rcnt_d;
      rlen_q    <= rlen_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized bench for axi_slave_mem: a plain word-array model predicts every
// write response and read beat from the burst rules.
module tb_axi_slave_mem;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 16;

  logic              aclk = 1'b0;
  logic              areset = 1'b0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [7:0]        awlen = 8'd0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DATA_W-1:0] wdata = '0;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [7:0]        arlen = 8'd0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready = 1'b0;

  axi_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_mem [MEM_DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge; returns just after the posedge where the handshake happened.
  task automatic wait_hs(input int ch);
    int t;
    bit hs;
    t = 0;
    forever begin
      case (ch)
        0:       hs = awready;
        1:       hs = wready;
        2:       hs = bvalid;
        default: hs = arready;
      endcase
      @(posedge aclk);
      if (hs) break;
      t++;
      if (t > 64) begin
        check_eq("hs_timeout", t, 0);
        break;
      end
      @(negedge aclk);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input int wlast_at,
                           input int bdelay, input bit gaps, input bit directed);
    int base, nbeats;
    logic [1:0] exp_resp;
    logic [31:0] d;
    base   = int'(addr >> 2);
    nbeats = ((wlast_at < len) ? wlast_at : len) + 1;
    exp_resp = ((base + nbeats > MEM_DEPTH) || (wlast_at != len)) ? 2'b10 : 2'b00;
    @(negedge aclk);
    awaddr = addr; awlen = len[7:0]; awvalid = 1'b1;
    wait_hs(0);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge aclk);
      d = directed ? 32'(b + 1) * 32'h11 : $urandom;
      wvalid = 1'b1; wdata = d; wlast = (b == wlast_at);
      wait_hs(1);
      if (base + b < MEM_DEPTH) model_mem[base + b] = d;
      @(negedge aclk);
      wvalid = 1'b0; wlast = 1'b0;
    end
    check_eq("bvalid_after_last", bvalid, 1'b1);
    check_eq("wready_in_resp", wready, 1'b0);
    for (int i = 0; i < bdelay; i++) begin
      check_eq("bresp_stall", bresp, exp_resp);
      @(negedge aclk);
      check_eq("bvalid_hold", bvalid, 1'b1);
    end
    bready = 1'b1;
    check_eq("bresp", bresp, exp_resp);
    wait_hs(2);
    @(negedge aclk);
    bready = 1'b0;
    check_eq("bvalid_clear", bvalid, 1'b0);
    check_eq("awready_back", awready, 1'b1);
  endtask

  // rmode: 0 = rready always high, 1 = pattern 1,0,0,1, 2 = random
  task automatic axi_read(input logic [31:0] addr, input int len, input int rmode);
    int base, k, cyc, idx;
    bit hs;
    logic [31:0] exp_d;
    base = int'(addr >> 2);
    @(negedge aclk);
    araddr = addr; arlen = len[7:0]; arvalid = 1'b1;
    wait_hs(3);
    @(negedge aclk);
    arvalid = 1'b0;
    k = 0; cyc = 0;
    while (k <= len) begin
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      idx   = base + k;
      exp_d = (idx < MEM_DEPTH) ? model_mem[idx] : 32'h0;
      check_eq("rvalid", rvalid, 1'b1);
      check_eq("rdata", rdata, exp_d);
      check_eq("rresp", rresp, (idx < MEM_DEPTH) ? 2'b00 : 2'b10);
      check_eq("rlast", rlast, (k == len) ? 1'b1 : 1'b0);
      hs = rvalid & rready;
      @(posedge aclk);
      if (hs) k++;
      cyc++;
      if (cyc > 400) begin
        check_eq("read_timeout", cyc, 0);
        break;
      end
      @(negedge aclk);
    end
    rready = 1'b0;
    check_eq("rvalid_end", rvalid, 1'b0);
    check_eq("rlast_end", rlast, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = 32'h0;
    #1;
    check_eq("rst_awready", awready, 1'b0);
    check_eq("rst_arready", arready, 1'b0);
    check_eq("rst_wready", wready, 1'b0);
    check_eq("rst_bvalid", bvalid, 1'b0);
    check_eq("rst_rvalid", rvalid, 1'b0);
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check_eq("rel_awready", awready, 1'b1);
    check_eq("rel_arready", arready, 1'b1);

    axi_write(32'h04, 3, 3, 0, 1'b0, 1'b1);
    axi_read(32'h07, 3, 0);
    axi_read(32'h04, 3, 1);
    axi_write(32'h38, 3, 3, 2, 1'b0, 1'b0);
    axi_read(32'h38, 3, 0);
    axi_write(32'h00, 3, 1, 1, 1'b0, 1'b0);
    axi_read(32'h00, 3, 2);

    fork
      axi_write(32'h20, 3, 3, 1, 1'b1, 1'b0);
      axi_read(32'h04, 3, 2);
    join

    for (int it = 0; it < 30; it++) begin
      int len;
      logic [31:0] addr;
      len  = $urandom_range(0, 5);
      addr = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        axi_write(addr, len, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : len,
                  $urandom_range(0, 2), 1'b1, 1'b0);
      else
        axi_read(addr, len, $urandom_range(0, 2));
    end

    // Abandon a read burst with a mid-cycle reset; memory must come back cleared.
    axi_write(32'h04, 0, 0, 0, 1'b0, 1'b1);
    @(negedge aclk);
    araddr = 32'h04; arlen = 8'd0; arvalid = 1'b1;
    wait_hs(3);
    @(negedge aclk);
    arvalid = 1'b0;
    check_eq("pre_rst_rvalid", rvalid, 1'b1);
    check_eq("pre_rst_rlast", rlast, 1'b1);
    check_eq("pre_rst_rdata", rdata, 32'h11);
    #2 areset = 1'b0;
    #1;
    check_eq("mid_rst_rvalid", rvalid, 1'b0);
    check_eq("mid_rst_rlast", rlast, 1'b0);
    check_eq("mid_rst_arready", arready, 1'b0);
    check_eq("mid_rst_awready", awready, 1'b0);
    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = 32'h0;
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check_eq("rel2_arready", arready, 1'b1);
    axi_read(32'h04, 0, 0);
    axi_read(32'h00, 7, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
